// File: rtl/ps2_host_tx_pkg.sv
// Shared types, command codes and cycle-count helpers for the PS/2 host transmitter.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE
  } state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  function automatic int us_to_cycles(input longint freq_hz, input longint us);
    return int'((freq_hz * us) / 64'd1_000_000);
  endfunction

  function automatic int ms_to_cycles(input longint freq_hz, input longint ms);
    return int'((freq_hz * ms) / 64'd1_000);
  endfunction

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and transaction status between a client and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       err;

  modport master (output tx_valid, tx_data, input tx_ready, busy, done, ack_ok, err);
  modport slave  (input tx_valid, tx_data, output tx_ready, busy, done, ack_ok, err);
endinterface

// File: rtl/ps2_edge_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pins plus a ps2_clk falling-edge pulse.
// The pulse is visible two cycles after the pin falls, so logic acting on it reacts on the third.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Lines idle high, so the flops reset high to avoid a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_i};
      data_ff  <= {data_ff[0], ps2_data_i};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];
  assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit shift on device clocks, ACK check.
// Accepts one byte only in IDLE (tx_ready); optional watchdog under PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int RTS_CYCLES  = 20,
  parameter int TIMEOUT_MS  = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int INHIBIT_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int WAIT_MAX    = (INHIBIT_CYC > RTS_CYCLES) ? INHIBIT_CYC : RTS_CYCLES;
  localparam int WAIT_W      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] INHIBIT_LAST = WAIT_W'(INHIBIT_CYC - 1);
  localparam logic [WAIT_W-1:0] RTS_LAST     = WAIT_W'(RTS_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [10:0]       frame;
  logic [3:0]        bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              ack_ok_q;
  logic              err_q;
  logic              clk_sync;
  logic              data_sync;
  logic              clk_fall;
  logic              accept;
  logic              timeout;

  ps2_edge_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .clk_fall   (clk_fall)
  );

  assign accept = tx.tx_valid && (state == IDLE);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TIMEOUT_CYC = ms_to_cycles(CLK_FREQ_HZ, TIMEOUT_MS);
  localparam int TO_W        = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt;

  // Runs from clock release until the ACK edge; cleared in every other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (state == SHIFT || state == ACK)
      to_cnt <= to_cnt + 1'b1;
    else
      to_cnt <= '0;
  end

  assign timeout = (state == SHIFT || state == ACK) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = INHIBIT;
      INHIBIT:   if (wait_cnt == INHIBIT_LAST) state_nxt = RTS;
      RTS:       if (wait_cnt == RTS_LAST) state_nxt = SHIFT;
      SHIFT:     if (timeout) state_nxt = DONE;
                 else if (clk_fall && bit_cnt == 4'd9) state_nxt = ACK;
      ACK:       if (timeout) state_nxt = DONE;
                 else if (clk_fall) state_nxt = WAIT_IDLE;
      WAIT_IDLE: if (clk_sync && data_sync) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // frame[0] is the bit on the wire; the start bit is already there while in RTS.
  always_comb begin
    tx.tx_ready = (state == IDLE);
    tx.busy     = (state != IDLE);
    tx.done     = (state == DONE);
    ps2_clk_oe  = (state == INHIBIT) || (state == RTS);
    ps2_data_oe = (state == RTS) || ((state == SHIFT) && !frame[0]);
  end

  assign tx.ack_ok = ack_ok_q;
  assign tx.err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame    <= '1;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      ack_ok_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if ((state == INHIBIT || state == RTS) && state_nxt == state)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      case (state)
        IDLE: if (accept) begin
          frame    <= {1'b1, odd_parity(tx.tx_data), tx.tx_data, 1'b0};
          bit_cnt  <= '0;
          ack_ok_q <= 1'b0;
          err_q    <= 1'b0;
        end
        SHIFT: if (clk_fall) begin
          frame   <= {1'b1, frame[10:1]};
          bit_cnt <= (bit_cnt == 4'd11) ? bit_cnt : bit_cnt + 4'd1;
        end
        ACK: if (clk_fall) begin
          bit_cnt  <= (bit_cnt == 4'd11) ? bit_cnt : bit_cnt + 4'd1;
          ack_ok_q <= ~data_sync;
          err_q    <= data_sync;
        end
        default: ;
      endcase

      if (timeout) begin
        ack_ok_q <= 1'b0;
        err_q    <= 1'b1;
      end
    end
  end

endmodule
